// File: rtl/cp0_regfile.sv
// MIPS32 coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Accepts one exception / ERET / MTC0 commit per cycle from MEM, runs the Count/Compare
// timer, and issues a one-cycle registered pipeline flush with its redirect PC.
//
// Commit handshake: a commit is accepted in a cycle only when stall is low. Exception
// beats ERET, ERET beats MTC0; any lower-priority commit in the same cycle is dropped.
// flush is a single-cycle pulse in the cycle after an accepted exception or ERET.
module cp0_regfile #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter bit          TIMER_EN   = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HW_INT_NUM-1:0] ext_int,
    input  logic                  stall,
    input  logic                  mtc0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [2:0]            cp0_wsel,
    input  logic [31:0]           cp0_wdata,
    input  logic [4:0]            cp0_raddr,
    input  logic [2:0]            cp0_rsel,
    output logic [31:0]           cp0_rdata,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    output logic                  int_req,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    localparam int              DIV_W        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(COUNT_DIV - 1);
    localparam logic [31:0]     STATUS_RESET = 32'h0040_0000;
    // Writable Status bits: IM[15:8], EXL[1], IE[0]; BEV and the rest are fixed.
    localparam logic [31:0]     STATUS_WMASK = 32'h0000_FF03;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [31:0]           status_q,   status_d;
    logic [31:0]           epc_q,      epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           compare_q,  compare_d;
    logic [DIV_W-1:0]      div_q,      div_d;
    logic                  bd_q,       bd_d;
    logic                  ti_q,       ti_d;
    logic [HW_INT_NUM-1:0] ip_hw_q,    ip_hw_d;
    logic [1:0]            ip_sw_q,    ip_sw_d;
    logic [4:0]            exccode_q,  exccode_d;
    logic                  flush_q,    flush_d;
    logic [31:0]           flush_pc_q, flush_pc_d;

    logic [7:0]  ip;
    logic [31:0] cause_val;
    logic        do_exc;
    logic        do_eret;
    logic        do_mtc0;

    // Accepted commit this cycle, after stall gating and priority.
    assign do_exc  = exc_valid & ~stall;
    assign do_eret = eret & ~stall & ~exc_valid;
    assign do_mtc0 = mtc0_we & ~stall & ~exc_valid & ~eret & (cp0_wsel == 3'd0);

    // Assemble Cause.IP (hardware lines, software bits, timer on IP7) and the Cause word.
    always_comb begin
        ip = 8'h00;
        ip[1:0] = ip_sw_q;
        ip[2 +: HW_INT_NUM] = ip_hw_q;
        if (TIMER_EN) begin
            ip[7] = ip[7] | ti_q;
        end
        cause_val = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b00};
    end

    // Next-state: timer, interrupt sampling, then commits in priority order.
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        div_d      = div_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_hw_d    = ext_int;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;

        // Timer: a Count write reloads and restarts the divider without incrementing.
        if (do_mtc0 && cp0_waddr == REG_COUNT) begin
            count_d = cp0_wdata;
            div_d   = '0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
            if (TIMER_EN && (count_q + 32'd1) == compare_q) begin
                ti_d = 1'b1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (do_exc) begin
            // Nested exceptions keep the original EPC/BD so the outer handler can return.
            if (!status_q[1]) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end
            exccode_d   = exc_code;
            status_d[1] = 1'b1;
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES) begin
                badvaddr_d = exc_badvaddr;
            end
            flush_d    = 1'b1;
            flush_pc_d = EXC_VECTOR;
        end else if (do_eret) begin
            status_d[1] = 1'b0;
            flush_d     = 1'b1;
            flush_pc_d  = epc_q;
        end else if (do_mtc0) begin
            case (cp0_waddr)
                REG_COMPARE: begin
                    compare_d = cp0_wdata;
                    ti_d      = 1'b0;
                end
                REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
                REG_CAUSE:  ip_sw_d  = cp0_wdata[9:8];
                REG_EPC:    epc_d    = cp0_wdata;
                default:    ;
            endcase
        end
    end

    // State registers; rst overrides everything including a pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            div_q      <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            div_q      <= div_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // MFC0 read port: current register state, no write bypass.
    always_comb begin
        cp0_rdata = 32'h0;
        if (cp0_rsel == 3'd0) begin
            case (cp0_raddr)
                REG_BADVADDR: cp0_rdata = badvaddr_q;
                REG_COUNT:    cp0_rdata = count_q;
                REG_COMPARE:  cp0_rdata = compare_q;
                REG_STATUS:   cp0_rdata = status_q;
                REG_CAUSE:    cp0_rdata = cause_val;
                REG_EPC:      cp0_rdata = epc_q;
                default:      cp0_rdata = 32'h0;
            endcase
        end
    end

    assign int_req  = status_q[0] & ~status_q[1] & (|(ip & status_q[15:8]));
    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;
    assign status_o = status_q;
    assign cause_o  = cause_val;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed commits with hand-computed expectations queued by the
// driver and checked by an independent monitor at each falling edge.
module tb_cp0_regfile;

    localparam int CLK_HALF = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int;
    logic        stall;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [2:0]  cp0_wsel;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [2:0]  cp0_rsel;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        int_req;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    typedef enum int {K_RD, K_STATUS, K_CAUSE, K_EPC, K_INT, K_FLUSH, K_NOFLUSH} kind_e;
    typedef struct {
        kind_e      kind;
        logic [4:0] addr;
        logic [2:0] sel;
    } meta_t;

    logic [31:0] exp_q[$];
    meta_t       meta_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    cp0_regfile #(
        .HW_INT_NUM(6),
        .COUNT_DIV (2),
        .TIMER_EN  (1'b1),
        .EXC_VECTOR(32'hBFC0_0380)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_int     (ext_int),
        .stall       (stall),
        .mtc0_we     (mtc0_we),
        .cp0_waddr   (cp0_waddr),
        .cp0_wsel    (cp0_wsel),
        .cp0_wdata   (cp0_wdata),
        .cp0_raddr   (cp0_raddr),
        .cp0_rsel    (cp0_rsel),
        .cp0_rdata   (cp0_rdata),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .exc_badvaddr(exc_badvaddr),
        .eret        (eret),
        .int_req     (int_req),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o)
    );

    // Clock
    always #CLK_HALF clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: drains everything queued this cycle, plus catches flushes nobody expected.
    initial begin : monitor
        meta_t       m;
        logic [31:0] e;
        string       n;
        logic        flush_seen;
        cp0_raddr = 5'd0;
        cp0_rsel  = 3'd0;
        forever begin
            @(negedge clk);
            flush_seen = 1'b0;
            while (exp_q.size() > 0) begin
                m = meta_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                cp0_raddr = m.addr;
                cp0_rsel  = m.sel;
                #1;
                case (m.kind)
                    K_RD:     compare(n, cp0_rdata, e);
                    K_STATUS: compare(n, status_o, e);
                    K_CAUSE:  compare(n, cause_o, e);
                    K_EPC:    compare(n, epc_o, e);
                    K_INT:    compare(n, {31'b0, int_req}, e);
                    K_FLUSH: begin
                        flush_seen = 1'b1;
                        compare({n, "_valid"}, {31'b0, flush}, 32'd1);
                        compare({n, "_pc"}, flush_pc, e);
                    end
                    default: begin
                        flush_seen = 1'b1;
                        compare(n, {31'b0, flush}, 32'd0);
                    end
                endcase
            end
            if (flush === 1'b1 && !flush_seen) begin
                n_checks++;
                $display("FAIL unexpected_flush: got flush=1 pc %h expected flush=0", flush_pc);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input kind_e k, input logic [4:0] a, input logic [2:0] s,
                              input logic [31:0] e, input string n);
        meta_t m;
        m.kind = k;
        m.addr = a;
        m.sel  = s;
        meta_q.push_back(m);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic exp_rd(input logic [4:0] a, input logic [31:0] e, input string n);
        expect_val(K_RD, a, 3'd0, e, n);
    endtask

    task automatic exp_sig(input kind_e k, input logic [31:0] e, input string n);
        expect_val(k, 5'd0, 3'd0, e, n);
    endtask

    task automatic set_mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we   = 1'b1;
        cp0_waddr = a;
        cp0_wsel  = 3'd0;
        cp0_wdata = d;
    endtask

    task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva);
        exc_valid    = 1'b1;
        exc_code     = code;
        exc_pc       = pc;
        exc_bd       = bd;
        exc_badvaddr = bva;
    endtask

    task automatic clear_cmds();
        mtc0_we   = 1'b0;
        exc_valid = 1'b0;
        eret      = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        set_mtc0(a, d);
        tick();
        clear_cmds();
    endtask

    // Stimulus
    initial begin : driver
        rst = 1'b1;
        ext_int = 6'd0;
        stall = 1'b0;
        mtc0_we = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wsel = 3'd0;
        cp0_wdata = 32'd0;
        exc_valid = 1'b0;
        exc_code = 5'd0;
        exc_pc = 32'd0;
        exc_bd = 1'b0;
        exc_badvaddr = 32'd0;
        eret = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // 1: reset values, read decode, Count every second clock
        exp_rd(5'd12, 32'h0040_0000, "rst_status");
        exp_rd(5'd13, 32'h0, "rst_cause");
        exp_rd(5'd14, 32'h0, "rst_epc");
        exp_rd(5'd9, 32'h0, "rst_count");
        exp_rd(5'd8, 32'h0, "rst_badvaddr");
        exp_sig(K_INT, 32'd0, "rst_int_req");
        exp_sig(K_NOFLUSH, 32'd0, "rst_flush");
        expect_val(K_RD, 5'd12, 3'd1, 32'h0, "rsel_nonzero");
        tick();
        tick();
        exp_rd(5'd9, 32'd1, "count_after_2clk");
        exp_rd(5'd15, 32'h0, "unimpl_reg");
        tick();
        tick();
        exp_rd(5'd9, 32'd2, "count_after_4clk");

        // 2: AdEL in delay slot, with a same-cycle Status write that must be lost
        set_exc(5'd4, 32'h8000_1004, 1'b1, 32'h3);
        set_mtc0(5'd12, 32'h1);
        tick();
        clear_cmds();
        exp_sig(K_FLUSH, 32'hBFC0_0380, "exc1_flush");
        exp_sig(K_EPC, 32'h8000_1000, "exc1_epc");
        exp_sig(K_STATUS, 32'h0040_0002, "exc1_status");
        exp_sig(K_CAUSE, 32'h8000_0010, "exc1_cause");
        exp_rd(5'd8, 32'h3, "exc1_badvaddr");
        tick();
        exp_sig(K_NOFLUSH, 32'd0, "exc1_flush_once");
        // nested Ov with EXL=1 keeps EPC/BD and BadVAddr
        set_exc(5'd12, 32'h8000_2000, 1'b0, 32'hDEAD);
        tick();
        clear_cmds();
        exp_sig(K_FLUSH, 32'hBFC0_0380, "exc2_flush");
        exp_sig(K_EPC, 32'h8000_1000, "exc2_epc_kept");
        exp_sig(K_CAUSE, 32'h8000_0030, "exc2_cause");
        exp_rd(5'd8, 32'h3, "exc2_badvaddr_kept");
        tick();
        exp_sig(K_NOFLUSH, 32'd0, "exc2_flush_once");

        // 3: ERET (same-cycle EPC write dropped)
        eret = 1'b1;
        set_mtc0(5'd14, 32'h1234_5678);
        tick();
        clear_cmds();
        exp_sig(K_FLUSH, 32'h8000_1000, "eret_flush");
        exp_sig(K_STATUS, 32'h0040_0000, "eret_status");
        exp_sig(K_EPC, 32'h8000_1000, "eret_epc");
        tick();
        exp_sig(K_NOFLUSH, 32'd0, "eret_flush_once");

        // 4: timer interrupt
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd8);
        exp_rd(5'd9, 32'd8, "count_loaded");
        exp_rd(5'd11, 32'd10, "compare_loaded");
        tick();
        tick();
        tick();
        exp_rd(5'd9, 32'd9, "count_9");
        exp_sig(K_CAUSE, 32'h8000_0030, "ti_clear_at_9");
        tick();
        exp_rd(5'd9, 32'd10, "count_10");
        exp_sig(K_CAUSE, 32'hC000_8030, "ti_set_at_10");
        exp_sig(K_INT, 32'd0, "ti_masked_ie0");
        mtc0(5'd12, 32'h8001);
        exp_sig(K_STATUS, 32'h0040_8001, "status_im7_ie");
        exp_sig(K_INT, 32'd1, "timer_int_req");
        mtc0(5'd11, 32'd0);
        exp_sig(K_CAUSE, 32'h8000_0030, "compare_clears_ti");
        exp_sig(K_INT, 32'd0, "timer_int_cleared");

        // 5: external interrupt, EXL masking, stall
        mtc0(5'd12, 32'h0801);
        ext_int = 6'b000010;
        exp_sig(K_INT, 32'd0, "ext_int_latency");
        tick();
        exp_sig(K_INT, 32'd1, "ext_int_req");
        exp_sig(K_CAUSE, 32'h8000_0830, "ext_int_cause");
        stall = 1'b1;
        set_exc(5'd0, 32'h8000_3000, 1'b0, 32'h0);
        tick();
        clear_cmds();
        exp_sig(K_NOFLUSH, 32'd0, "stall_no_flush");
        exp_sig(K_EPC, 32'h8000_1000, "stall_epc");
        exp_sig(K_STATUS, 32'h0040_0801, "stall_status");
        exp_sig(K_CAUSE, 32'h8000_0830, "stall_cause");
        set_exc(5'd0, 32'h8000_3000, 1'b0, 32'h0);
        tick();
        clear_cmds();
        exp_sig(K_FLUSH, 32'hBFC0_0380, "int_flush");
        exp_sig(K_STATUS, 32'h0040_0803, "int_status");
        exp_sig(K_INT, 32'd0, "exl_masks_int");
        exp_sig(K_CAUSE, 32'h0000_0800, "int_cause");
        exp_sig(K_EPC, 32'h8000_3000, "int_epc");
        tick();
        exp_sig(K_NOFLUSH, 32'd0, "int_flush_once");

        // 6: Count wrap hits Compare=0, then reset during a flush
        ext_int = 6'd0;
        mtc0(5'd9, 32'hFFFF_FFFF);
        exp_rd(5'd9, 32'hFFFF_FFFF, "count_max");
        tick();
        tick();
        exp_rd(5'd9, 32'h0, "count_wrap");
        exp_sig(K_CAUSE, 32'h4000_8000, "wrap_ti_cause");
        eret = 1'b1;
        tick();
        clear_cmds();
        exp_sig(K_FLUSH, 32'h8000_3000, "eret2_flush");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_sig(K_NOFLUSH, 32'd0, "rst_kills_flush");
        exp_sig(K_STATUS, 32'h0040_0000, "rst2_status");
        exp_sig(K_CAUSE, 32'h0, "rst2_cause");
        exp_sig(K_EPC, 32'h0, "rst2_epc");
        exp_rd(5'd9, 32'h0, "rst2_count");
        exp_rd(5'd11, 32'h0, "rst2_compare");
        exp_rd(5'd8, 32'h0, "rst2_badvaddr");
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
